// File: rtl/adder_seq_ctrl_if.sv
// Bundle of the request, response and status signals of adder_seq_ctrl.
// The host side uses the master modport; the controller uses the slave one.
// Optional macro ADDER_SEQ_OVF_EN adds rsp_ovf (two's-complement overflow).
interface adder_seq_ctrl_if #(
  parameter int WORDS = 4
);
  localparam int W = 3 * WORDS;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_id;
`ifdef ADDER_SEQ_OVF_EN
  logic         rsp_ovf;
`endif

  logic         busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output rsp_ready,
`ifdef ADDER_SEQ_OVF_EN
    input  rsp_ovf,
`endif
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  rsp_ready,
`ifdef ADDER_SEQ_OVF_EN
    output rsp_ovf,
`endif
    output req0_ready, req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id, busy
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// Shared multi-cycle adder: one 3-bit slice with a registered carry is
// time-multiplexed over WORDS slices, serving two round-robin requesters.
// Optional macro ADDER_SEQ_OVF_EN adds the registered rsp_ovf output.
module adder_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  adder_seq_ctrl_if.slave  bus
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   id_q, id_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic [WORDS-1:0][2:0]  a_q, a_d;
  logic [WORDS-1:0][2:0]  b_q, b_d;
  logic [WORDS-1:0][2:0]  sum_q, sum_d;
`ifdef ADDER_SEQ_OVF_EN
  logic                   ovf_q, ovf_d;
`endif

  logic       grant_vld;
  logic       grant_id;
  logic [2:0] a_sl;
  logic [2:0] b_sl;
  logic [2:0] slice_sum;
  logic       slice_cout;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_vld = bus.req0_valid | bus.req1_valid;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_q;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign bus.req0_ready = (state_q == IDLE) && grant_vld && !grant_id;
  assign bus.req1_ready = (state_q == IDLE) && grant_vld &&  grant_id;

  // The shared 3-bit slice operating on the slice selected by idx.
  always_comb begin
    a_sl = a_q[idx_q];
    b_sl = b_q[idx_q];
    {slice_cout, slice_sum} = {1'b0, a_sl} + {1'b0, b_sl} + {3'b000, carry_q};
  end

  // Next-state and datapath update for IDLE -> ADD -> DONE sequencing.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
`ifdef ADDER_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          a_d     = grant_id ? bus.req1_a   : bus.req0_a;
          b_d     = grant_id ? bus.req1_b   : bus.req0_b;
          carry_d = grant_id ? bus.req1_cin : bus.req0_cin;
          sum_d   = '0;
          idx_d   = '0;
          id_d    = grant_id;
          last_d  = grant_id;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[idx_q] = slice_sum;
        carry_d      = slice_cout;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = DONE;
`ifdef ADDER_SEQ_OVF_EN
          // Carry into the MSB is recovered from the top slice's bit 2.
          ovf_d = (a_sl[2] ^ b_sl[2] ^ slice_sum[2]) ^ slice_cout;
`endif
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = carry_q;
  assign bus.rsp_id    = id_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef ADDER_SEQ_OVF_EN
  assign bus.rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl: a WORDS=4 instance for the protocol
// scenarios and a WORDS=1 instance swept over every operand combination.
module tb_adder_seq_ctrl;

  localparam int WORDS4 = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  adder_seq_ctrl_if #(.WORDS(WORDS4)) if4 ();
  adder_seq_ctrl_if #(.WORDS(1))      if1 ();

  adder_seq_ctrl #(.WORDS(WORDS4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  adder_seq_ctrl #(.WORDS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WORDS=4 operation with rsp_ready held high, checking cycle timing.
  task automatic op4(input logic port, input logic [11:0] a, input logic [11:0] b,
                     input logic cin, input logic [11:0] exp_sum, input logic exp_cout,
                     input logic exp_ovf);
    if4.rsp_ready = 1'b1;
    if (port) begin
      if4.req1_a = a; if4.req1_b = b; if4.req1_cin = cin; if4.req1_valid = 1'b1;
    end else begin
      if4.req0_a = a; if4.req0_b = b; if4.req0_cin = cin; if4.req0_valid = 1'b1;
    end
    #1;
    check("op_ready", {if4.req1_ready, if4.req0_ready}, port ? 2'b10 : 2'b01);
    tick();
    if4.req0_valid = 1'b0;
    if4.req1_valid = 1'b0;
    check("op_busy", if4.busy, 1'b1);
    repeat (WORDS4 - 1) tick();
    check("op_early_valid", if4.rsp_valid, 1'b0);
    tick();
    check("op_valid", if4.rsp_valid, 1'b1);
    check("op_sum", if4.rsp_sum, exp_sum);
    check("op_cout", if4.rsp_cout, exp_cout);
    check("op_id", if4.rsp_id, port);
`ifdef ADDER_SEQ_OVF_EN
    check("op_ovf", if4.rsp_ovf, exp_ovf);
`endif
    $display("op port=%0d a=0x%03h b=0x%03h cin=%0d -> sum=0x%03h cout=%0d id=%0d (exp ovf=%0d)",
             port, a, b, cin, if4.rsp_sum, if4.rsp_cout, if4.rsp_id, exp_ovf);
    tick();
    check("op_idle", {if4.busy, if4.rsp_valid}, 2'b00);
  endtask

  // One WORDS=1 operation: accept, one ADD cycle, then DONE.
  task automatic op1(input logic port, input logic [2:0] a, input logic [2:0] b, input logic cin);
    logic [3:0] exp_res;
    exp_res = {1'b0, a} + {1'b0, b} + {3'b000, cin};
    if1.rsp_ready = 1'b1;
    if (port) begin
      if1.req1_a = a; if1.req1_b = b; if1.req1_cin = cin; if1.req1_valid = 1'b1;
    end else begin
      if1.req0_a = a; if1.req0_b = b; if1.req0_cin = cin; if1.req0_valid = 1'b1;
    end
    tick();
    if1.req0_valid = 1'b0;
    if1.req1_valid = 1'b0;
    tick();
    check("w1_result", {if1.rsp_valid, if1.rsp_id, if1.rsp_cout, if1.rsp_sum},
          {1'b1, port, exp_res});
    $display("w1 port=%0d a=%0d b=%0d cin=%0d -> cout=%0d sum=%0d", port, a, b, cin,
             if1.rsp_cout, if1.rsp_sum);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    if4.req0_valid = 1'b0; if4.req0_a = '0; if4.req0_b = '0; if4.req0_cin = 1'b0;
    if4.req1_valid = 1'b0; if4.req1_a = '0; if4.req1_b = '0; if4.req1_cin = 1'b0;
    if4.rsp_ready  = 1'b0;
    if1.req0_valid = 1'b0; if1.req0_a = '0; if1.req0_b = '0; if1.req0_cin = 1'b0;
    if1.req1_valid = 1'b0; if1.req1_a = '0; if1.req1_b = '0; if1.req1_cin = 1'b0;
    if1.rsp_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", if4.rsp_valid, 1'b0);
    check("rst_sum", if4.rsp_sum, 12'h000);
    check("rst_cout_id", {if4.rsp_cout, if4.rsp_id}, 2'b00);
    check("rst_busy", if4.busy, 1'b0);
    check("rst_ready", {if4.req1_ready, if4.req0_ready}, 2'b00);
`ifdef ADDER_SEQ_OVF_EN
    check("rst_ovf", if4.rsp_ovf, 1'b0);
`endif

    // Single op wrapping to zero, then carry ripple through all slices
    op4(1'b0, 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0);
    op4(1'b0, 12'h7FF, 12'h000, 1'b1, 12'h800, 1'b0, 1'b1);

    // Tie and fairness from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if4.rsp_ready  = 1'b1;
    if4.req0_a = 12'h123; if4.req0_b = 12'h456; if4.req0_cin = 1'b0; if4.req0_valid = 1'b1;
    if4.req1_a = 12'hABC; if4.req1_b = 12'h654; if4.req1_cin = 1'b1; if4.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("tie_grant", {if4.req1_ready, if4.req0_ready}, (i % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      repeat (WORDS4) tick();
      check("tie_id", if4.rsp_id, (i % 2 == 1) ? 1'b1 : 1'b0);
      check("tie_res", {if4.rsp_valid, if4.rsp_cout, if4.rsp_sum},
            (i % 2 == 1) ? {1'b1, 1'b1, 12'h111} : {1'b1, 1'b0, 12'h579});
      $display("tie op %0d id=%0d sum=0x%03h cout=%0d", i, if4.rsp_id, if4.rsp_sum, if4.rsp_cout);
      tick();
    end
    if4.req0_valid = 1'b0;
    if4.req1_valid = 1'b0;

    // Back-pressure: DONE holds while rsp_ready is low, no new grant
    if4.rsp_ready = 1'b0;
    if4.req0_a = 12'h555; if4.req0_b = 12'h222; if4.req0_cin = 1'b0; if4.req0_valid = 1'b1;
    #1;
    tick();
    if4.req0_valid = 1'b0;
    if4.req1_valid = 1'b1;
    repeat (WORDS4) tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {if4.rsp_valid, if4.busy, if4.rsp_id, if4.rsp_cout, if4.rsp_sum},
            {1'b1, 1'b1, 1'b0, 1'b0, 12'h777});
      check("bp_ready", {if4.req1_ready, if4.req0_ready}, 2'b00);
      tick();
    end
    $display("bp op sum=0x%03h held for 10 cycles", if4.rsp_sum);
    if4.req1_valid = 1'b0;
    if4.rsp_ready  = 1'b1;
    tick();
    check("bp_release", {if4.rsp_valid, if4.busy}, 2'b00);

    // Reset in the second ADD cycle discards the operation
    if4.req1_a = 12'h123; if4.req1_b = 12'h456; if4.req1_cin = 1'b1; if4.req1_valid = 1'b1;
    #1;
    tick();
    if4.req1_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_out", {if4.rsp_valid, if4.busy, if4.rsp_id, if4.rsp_cout, if4.rsp_sum},
          {1'b0, 1'b0, 1'b0, 1'b0, 12'h000});
    op4(1'b1, 12'h123, 12'h456, 1'b1, 12'h57A, 1'b0, 1'b0);

    // Exhaustive WORDS=1 sweep through both ports
    for (int v = 0; v < 256; v++) begin
      logic [7:0] vv;
      vv = 8'(v);
      op1(vv[7], vv[2:0], vv[5:3], vv[6]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
